// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam int unsigned         TIMEOUT_DEF   = 16;
  localparam logic [DATA_W-1:0]   ERR_RDATA_DEF = 32'hdead_beef;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Memory command captured at grant time and replayed onto the memory bus.
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  function automatic owner_e other_port(owner_e o);
    return (o == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory buses of the arbiter; slave is the arbiter's view,
// master is the surrounding system (fetch unit, LSU and memory).
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              instr_req_i;
  logic [ADDR_W-1:0] instr_addr_i;
  logic [DATA_W-1:0] instr_rdata_o;
  logic              instr_ready_o;
  logic              instr_err_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [BE_W-1:0]   data_be_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_ready_o;
  logic              data_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_rdata_o, instr_ready_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_rdata_o, data_ready_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_rdata_o, instr_ready_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_rdata_o, data_ready_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; on contention the port that did not win last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,     // [0] instr, [1] data
  input  logic       update_i,
  output owner_e     grant_c,
  output logic       valid_c
);

  owner_e last_q;

  // Reset to DATA so the first contended grant goes to the fetch port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= OWN_DATA;
    end else if (update_i) begin
      last_q <= grant_c;
    end
  end

  always_comb begin
    valid_c = |req_i;
    grant_c = OWN_INSTR;
    if (req_i[0] && req_i[1]) begin
      grant_c = other_port(last_q);
    end else if (req_i[1]) begin
      grant_c = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory between the fetch unit and the LSU, one
// transaction at a time, with a watchdog that aborts unacknowledged accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t            state_q, state_d;
  owner_e            owner_q, owner_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              mem_req_q, mem_req_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic              instr_ready_q, instr_ready_d;
  logic              instr_err_q, instr_err_d;
  logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
  logic              data_ready_q, data_ready_d;
  logic              data_err_q, data_err_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  owner_e            arb_grant_c;
  logic              arb_valid_c;
  logic              arb_update_c;
  logic              rsp_fire_c;
  logic              rsp_err_c;
  logic [DATA_W-1:0] rsp_rdata_c;

  rr_arb2 u_rr_arb2 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({bus.data_req_i, bus.instr_req_i}),
    .update_i (arb_update_c),
    .grant_c  (arb_grant_c),
    .valid_c  (arb_valid_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_INSTR;
      cmd_q         <= '0;
      mem_req_q     <= 1'b0;
      wdog_q        <= '0;
      instr_ready_q <= 1'b0;
      instr_err_q   <= 1'b0;
      instr_rdata_q <= '0;
      data_ready_q  <= 1'b0;
      data_err_q    <= 1'b0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cmd_q         <= cmd_d;
      mem_req_q     <= mem_req_d;
      wdog_q        <= wdog_d;
      instr_ready_q <= instr_ready_d;
      instr_err_q   <= instr_err_d;
      instr_rdata_q <= instr_rdata_d;
      data_ready_q  <= data_ready_d;
      data_err_q    <= data_err_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  // Next-state and next-output logic; outputs are registered so they line up with state_q.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cmd_d        = cmd_q;
    mem_req_d    = 1'b0;
    wdog_d       = wdog_q;
    arb_update_c = 1'b0;
    rsp_fire_c   = 1'b0;
    rsp_err_c    = 1'b0;
    rsp_rdata_c  = '0;

    case (state_q)
      S_IDLE: begin
        if (arb_valid_c) begin
          arb_update_c = 1'b1;
          owner_d      = arb_grant_c;
          mem_req_d    = 1'b1;
          state_d      = S_ISSUE;
          if (arb_grant_c == OWN_INSTR) begin
            cmd_d = '{we: 1'b0, be: {BE_W{1'b1}}, addr: bus.instr_addr_i, wdata: '0};
          end else begin
            cmd_d = '{we: bus.data_we_i, be: bus.data_be_i,
                      addr: bus.data_addr_i, wdata: bus.data_wdata_i};
          end
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_ready_i) begin
          rsp_fire_c  = 1'b1;
          rsp_rdata_c = bus.mem_rdata_i;
          state_d     = S_RESP;
        end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_fire_c  = 1'b1;
          rsp_err_c   = 1'b1;
          rsp_rdata_c = ERR_RDATA;
          state_d     = S_RESP;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Route the response only to the owner; the other port stays quiet.
    instr_ready_d = rsp_fire_c && (owner_q == OWN_INSTR);
    instr_err_d   = instr_ready_d && rsp_err_c;
    instr_rdata_d = instr_ready_d ? rsp_rdata_c : '0;
    data_ready_d  = rsp_fire_c && (owner_q == OWN_DATA);
    data_err_d    = data_ready_d && rsp_err_c;
    data_rdata_d  = data_ready_d ? rsp_rdata_c : '0;
  end

  assign bus.mem_req_o     = mem_req_q;
  assign bus.mem_we_o      = cmd_q.we;
  assign bus.mem_be_o      = cmd_q.be;
  assign bus.mem_addr_o    = cmd_q.addr;
  assign bus.mem_wdata_o   = cmd_q.wdata;
  assign bus.instr_ready_o = instr_ready_q;
  assign bus.instr_err_o   = instr_err_q;
  assign bus.instr_rdata_o = instr_rdata_q;
  assign bus.data_ready_o  = data_ready_q;
  assign bus.data_err_o    = data_err_q;
  assign bus.data_rdata_o  = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (fixed 3-cycle latency, 4-cycle slots, round-robin).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int          TO   = 16;
  localparam logic [31:0] ERRD = 32'hdead_beef;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  int          mem_lat = 1;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Memory model: acts on a request seen during the ISSUE cycle, answers mem_lat cycles later.
  // Addresses at or above 0x400 are never acknowledged.
  task automatic mem_proc();
    int          pend;
    logic [31:0] pend_rd;
    pend = 0;
    pend_rd = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      cyc();
      bus.mem_ready_i = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          bus.mem_ready_i = 1'b1;
          bus.mem_rdata_i = pend_rd;
        end
      end
      if (bus.mem_req_o === 1'b1 && bus.mem_addr_o < 32'h400) begin
        if (bus.mem_we_o)
          mem[bus.mem_addr_o[9:2]] = merge(mem[bus.mem_addr_o[9:2]], bus.mem_wdata_o, bus.mem_be_o);
        pend_rd = mem[bus.mem_addr_o[9:2]];
        pend = mem_lat;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = '0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
  endtask

  task automatic do_reset(int n);
    rst_i = 1'b1;
    idle_inputs();
    repeat (n) cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if ({bus.instr_ready_o, bus.instr_err_o, bus.data_ready_o, bus.data_err_o, bus.mem_req_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {bus.instr_ready_o, bus.instr_err_o, bus.data_ready_o, bus.data_err_o, bus.mem_req_o});
    end
    n_checks++;
    if ({bus.instr_rdata_o, bus.data_rdata_o} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h, expected 0", {bus.instr_rdata_o, bus.data_rdata_o});
    end
    n_checks++;
    if ({bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== 69'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got %h, expected 0",
               {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o});
    end
  endtask

  task automatic test_instr_read();
    cyc();
    mem[4] = 32'h0000_0013;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h10;
    cyc();
    n_checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o} !== {1'b1, 1'b0, 4'hf, 32'h10}) begin
      n_fail++;
      $display("FAIL ird_issue: got req=%b we=%b be=%h addr=%h, expected 1 0 f 10",
               bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o);
    end
    cyc();
    n_checks++;
    if ({bus.mem_req_o, bus.instr_ready_o, bus.mem_addr_o} !== {1'b0, 1'b0, 32'h10}) begin
      n_fail++;
      $display("FAIL ird_wait: got req=%b rdy=%b addr=%h, expected 0 0 10",
               bus.mem_req_o, bus.instr_ready_o, bus.mem_addr_o);
    end
    cyc();
    n_checks++;
    if ({bus.instr_ready_o, bus.instr_err_o, bus.data_ready_o, bus.instr_rdata_o} !== {3'b100, 32'h13}) begin
      n_fail++;
      $display("FAIL ird_resp: got rdy=%b err=%b drdy=%b rdata=%h, expected 1 0 0 00000013",
               bus.instr_ready_o, bus.instr_err_o, bus.data_ready_o, bus.instr_rdata_o);
    end
    bus.instr_req_i = 1'b0;
    cyc();
    n_checks++;
    if ({bus.instr_ready_o, bus.instr_rdata_o} !== 33'h0) begin
      n_fail++;
      $display("FAIL ird_after: got rdy=%b rdata=%h, expected 0 0", bus.instr_ready_o, bus.instr_rdata_o);
    end
  endtask

  task automatic test_write_read();
    int t1, t2;
    t1 = 0;
    t2 = 0;
    cyc();
    mem[8] = 32'h1234_0000;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'b0011;
    bus.data_addr_i  = 32'h20;
    bus.data_wdata_i = 32'hAAAA_5555;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (bus.data_ready_o === 1'b1 && t1 == 0) begin
        t1 = k;
        n_checks++;
        if (bus.data_err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_err: got %b, expected 0", bus.data_err_o);
        end
        bus.data_we_i = 1'b0;
      end else if (bus.data_ready_o === 1'b1) begin
        t2 = k;
        n_checks++;
        if ({bus.data_err_o, bus.data_rdata_o} !== {1'b0, 32'h1234_5555}) begin
          n_fail++;
          $display("FAIL rd_after_wr: got err=%b rdata=%h, expected 0 12345555", bus.data_err_o, bus.data_rdata_o);
        end
        bus.data_req_i = 1'b0;
        break;
      end
    end
    n_checks++;
    if (t1 != 3 || t2 - t1 != 4) begin
      n_fail++;
      $display("FAIL wr_rd_timing: got pulses at %0d and %0d, expected 3 and 7", t1, t2);
    end
  endtask

  task automatic test_contention();
    int p;
    int exp_own [4];
    exp_own = '{0, 1, 0, 1};
    p = 0;
    do_reset(2);
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h4;
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = 32'h8;
    for (int k = 1; k <= 30 && p < 4; k++) begin
      cyc();
      if (bus.instr_ready_o === 1'b1 || bus.data_ready_o === 1'b1) begin
        n_checks++;
        if ({bus.instr_ready_o, bus.data_ready_o} !== (exp_own[p] == 0 ? 2'b10 : 2'b01) || k != 3 + 4 * p) begin
          n_fail++;
          $display("FAIL rr_order: pulse %0d got irdy=%b drdy=%b at cycle %0d, expected owner %0d at %0d",
                   p, bus.instr_ready_o, bus.data_ready_o, k, exp_own[p], 3 + 4 * p);
        end
        n_checks++;
        if ((exp_own[p] == 0 ? bus.instr_rdata_o : bus.data_rdata_o) !== (exp_own[p] == 0 ? 32'h1111_1111 : 32'h2222_2222)) begin
          n_fail++;
          $display("FAIL rr_rdata: pulse %0d got %h/%h", p, bus.instr_rdata_o, bus.data_rdata_o);
        end
        p++;
      end
    end
    idle_inputs();
    n_checks++;
    if (p != 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d pulses, expected 4", p);
    end
  endtask

  task automatic test_timeout();
    int t, nreq;
    t = 0;
    nreq = 0;
    cyc();
    bus.data_req_i  = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = 32'h4000;
    for (int k = 1; k <= TO + 10; k++) begin
      cyc();
      if (bus.mem_req_o === 1'b1) nreq++;
      if (bus.data_ready_o === 1'b1) begin
        t = k;
        break;
      end
    end
    n_checks++;
    if (t != TO + 2 || nreq != 1) begin
      n_fail++;
      $display("FAIL to_latency: got ready at %0d with %0d mem reqs, expected %0d and 1", t, nreq, TO + 2);
    end
    n_checks++;
    if ({bus.data_err_o, bus.data_rdata_o, bus.instr_ready_o} !== {1'b1, ERRD, 1'b0}) begin
      n_fail++;
      $display("FAIL to_resp: got err=%b rdata=%h irdy=%b, expected 1 deadbeef 0",
               bus.data_err_o, bus.data_rdata_o, bus.instr_ready_o);
    end
    bus.data_req_i   = 1'b0;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h4;
    t = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (bus.instr_ready_o === 1'b1) begin
        t = k;
        n_checks++;
        if ({bus.instr_err_o, bus.instr_rdata_o} !== {1'b0, 32'h1111_1111}) begin
          n_fail++;
          $display("FAIL to_recover: got err=%b rdata=%h, expected 0 11111111", bus.instr_err_o, bus.instr_rdata_o);
        end
        break;
      end
    end
    bus.instr_req_i = 1'b0;
    n_checks++;
    if (t != 4) begin
      n_fail++;
      $display("FAIL to_recover_lat: got %0d, expected 4", t);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    cyc();
    mem_lat = 3;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h10;
    cyc();
    cyc();
    rst_i = 1'b1;
    bus.instr_req_i = 1'b0;
    cyc();
    rst_i = 1'b0;
    n_checks++;
    if ({bus.instr_ready_o, bus.data_ready_o, bus.mem_req_o, bus.mem_addr_o, bus.mem_be_o, bus.instr_rdata_o} !== 71'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got irdy=%b drdy=%b req=%b addr=%h be=%h, expected all 0",
               bus.instr_ready_o, bus.data_ready_o, bus.mem_req_o, bus.mem_addr_o, bus.mem_be_o);
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (bus.instr_ready_o !== 1'b0 || bus.data_ready_o !== 1'b0 || bus.mem_req_o !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_mid_stale: got %0d cycles with activity, expected 0", seen);
    end
    mem_lat = 1;
  endtask

  task automatic test_addr_change();
    int t;
    t = 0;
    cyc();
    mem_lat = 3;
    mem[4]  = 32'h0000_0013;
    mem[32] = 32'h55AA_55AA;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h10;
    cyc();
    cyc();
    bus.instr_addr_i = 32'h80;
    cyc();
    n_checks++;
    if (bus.mem_addr_o !== 32'h10) begin
      n_fail++;
      $display("FAIL addr_hold: got %h, expected 00000010", bus.mem_addr_o);
    end
    for (int k = 4; k <= 12; k++) begin
      cyc();
      if (bus.instr_ready_o === 1'b1) begin
        t = k;
        n_checks++;
        if (bus.instr_rdata_o !== 32'h13) begin
          n_fail++;
          $display("FAIL addr_data: got %h, expected 00000013", bus.instr_rdata_o);
        end
        break;
      end
    end
    bus.instr_req_i = 1'b0;
    mem_lat = 1;
    n_checks++;
    if (t != 5) begin
      n_fail++;
      $display("FAIL addr_latency: got %0d, expected 5", t);
    end
  endtask

  task automatic test_random(int ncyc);
    logic [31:0] ref_mem [0:15];
    logic [31:0] exp_rd, v;
    bit          i_act, d_act, exp_we;
    int          next_free, last_own, exp_done, exp_own, req_cyc, own, w;
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    i_act = 0; d_act = 0; exp_we = 0; exp_rd = '0;
    next_free = 0; last_own = 1; exp_done = -1; exp_own = 0; req_cyc = -10;
    for (int t = 0; t < ncyc; t++) begin
      cyc();
      n_checks++;
      if (bus.mem_req_o !== 1'(t == req_cyc) ||
          bus.instr_ready_o !== 1'(t == exp_done && exp_own == 0) ||
          bus.data_ready_o !== 1'(t == exp_done && exp_own == 1)) begin
        n_fail++;
        $display("FAIL rnd_timing: cycle %0d got req=%b irdy=%b drdy=%b, expected %b %b %b", t,
                 bus.mem_req_o, bus.instr_ready_o, bus.data_ready_o, 1'(t == req_cyc),
                 1'(t == exp_done && exp_own == 0), 1'(t == exp_done && exp_own == 1));
      end
      if (t == exp_done) begin
        n_checks++;
        if ((exp_own == 0 ? bus.instr_err_o : bus.data_err_o) !== 1'b0 ||
            (!exp_we && (exp_own == 0 ? bus.instr_rdata_o : bus.data_rdata_o) !== exp_rd)) begin
          n_fail++;
          $display("FAIL rnd_data: cycle %0d owner %0d got rdata=%h/%h err=%b/%b, expected %h", t, exp_own,
                   bus.instr_rdata_o, bus.data_rdata_o, bus.instr_err_o, bus.data_err_o, exp_rd);
        end
        if (exp_own == 0) i_act = 0;
        else d_act = 0;
      end
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1;
        bus.instr_addr_i = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1;
        bus.data_we_i    = 1'($urandom_range(0, 1));
        bus.data_be_i    = 4'($urandom);
        bus.data_addr_i  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus.data_wdata_i = $urandom;
      end
      bus.instr_req_i = i_act;
      bus.data_req_i  = d_act;
      if (t >= next_free && (i_act || d_act)) begin
        own = (i_act && d_act) ? 1 - last_own : (i_act ? 0 : 1);
        last_own = own; exp_own = own;
        req_cyc = t + 1; exp_done = t + 3; next_free = t + 4;
        w = (own == 0) ? int'(bus.instr_addr_i[5:2]) : int'(bus.data_addr_i[5:2]);
        exp_we = (own == 1) && bus.data_we_i;
        if (exp_we) ref_mem[w] = merge(ref_mem[w], bus.data_wdata_i, bus.data_be_i);
        exp_rd = ref_mem[w];
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    fork
      mem_proc();
      begin
        test_reset();
        test_instr_read();
        test_write_read();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_addr_change();
        test_random(400);
        repeat (4) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    join_any
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single external data/instruction memory between the core's instruction-fetch unit and its load/store unit.
- Accepts one request at a time and round-robins between the ports on contention.
- Issues a single-cycle request to the memory and waits for its ready pulse.
- Returns read data and a one-cycle ready pulse to the owning requester.
- A watchdog counter terminates transactions the memory never acknowledges, such as out-of-range reads, and flags them as errors.

Parameters:
TIMEOUT_CYCLES, 16, WAIT-state cycles without mem_ready_i before the transaction is aborted with error (min 2)
ERR_RDATA, 32'hdead_beef, read data returned on timeout

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous active-high reset
instr_req_i  input  1  fetch request; held with stable address until instr_ready_o
instr_addr_i  input  32  fetch byte address (read only)
instr_rdata_o  output  32  fetch read data, valid while instr_ready_o=1
instr_ready_o  output  1  one-cycle completion pulse
instr_err_o  output  1  with instr_ready_o: transaction timed out
data_req_i  input  1  LSU request; held stable until data_ready_o
data_we_i  input  1  1=write, 0=read
data_be_i  input  4  byte enables
data_addr_i  input  32  LSU byte address
data_wdata_i  input  32  write data
data_rdata_o  output  32  LSU read data, valid while data_ready_o=1
data_ready_o  output  1  one-cycle completion pulse
data_err_o  output  1  with data_ready_o: transaction timed out
mem_req_o  output  1  memory request, high exactly one cycle per transaction
mem_we_o  output  1  memory write enable
mem_be_o  output  4  memory byte enables
mem_addr_o  output  32  memory byte address
mem_wdata_o  output  32  memory write data
mem_rdata_i  input  32  memory read data (registered in memory)
mem_ready_i  input  1  memory completion pulse (one cycle after request)

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0; latched request fields 0; watchdog 0.
  - last_grant=DATA, so the first contended grant goes to INSTR.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If exactly one req_i is high, grant it.
  - If both are high, grant the port other than last_grant.
  - Latch owner, we, be, addr, wdata (instr: we=0, be=4'b1111); update last_grant; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - mem_req_o=1; mem_* driven from latched fields; go to WAIT; clear watchdog.
- WAIT:
  - mem_req_o=0; mem_we/be/addr/wdata keep their latched values.
  - If mem_ready_i: latch mem_rdata_i, err=0, go to RESP.
  - Else increment watchdog. When it reaches TIMEOUT_CYCLES-1, latch rdata=ERR_RDATA, err=1, go to RESP.
- RESP:
  - Owner's ready_o=1, its rdata_o=latched data, its err_o=latched err; go to IDLE.
  - The non-owner's ready/err stay 0.
  - rdata_o of both ports is 0 outside RESP.
- Requester rule: a req_i still high in the cycle after its ready pulse is a new request.
- Latency, uncontended with 1-cycle memory:
  - req seen in IDLE at cycle N; mem_req_o at N+1; ready_o at N+3.
  - Back-to-back throughput: one transaction per 4 cycles.
- Writes return rdata as captured from the memory (its write-path read value). Requesters must ignore rdata on writes.
- mem_ready_i outside WAIT is ignored. This covers a stale pulse after reset.
- Changes on req/addr inputs after latching have no effect on the in-flight transaction.
- Reset mid-transaction: next cycle is IDLE with all outputs 0. No ready pulse is issued for the aborted transaction.
- Watchdog width: $clog2(TIMEOUT_CYCLES)+1; no wrap.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - owner enum (OWN_INSTR, OWN_DATA)
  - default ERR_RDATA and TIMEOUT constants
- One sub-module rr_arb2: 2-way round-robin grant logic with last_grant register and update-enable input.
- FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- Instr read addr 0x10, memory word 0x0000_0013 -> mem_req_o one cycle; instr_ready_o 3 cycles after req; instr_rdata_o=0x0000_0013; err=0.
- Data write addr 0x20, be=4'b0011, wdata=0xAAAA_5555, then data read 0x20 (preset 0x1234_0000) -> second read returns 0x1234_5555; data_ready_o pulses 4 cycles apart.
- Both req high from reset, held over 4 transactions -> grant order INSTR, DATA, INSTR, DATA; no ready pulses to the non-owner.
- Data read addr 0x4000 with no mem ready -> data_ready_o after TIMEOUT_CYCLES WAIT cycles; data_err_o=1; data_rdata_o=0xdead_beef; next request served normally.
- rst_i asserted in WAIT -> next cycle all outputs 0, state IDLE; the memory's late ready pulse produces no requester ready.
- Requester changes addr from 0x10 to 0x80 during WAIT -> mem_addr_o stays 0x10; response carries the 0x10 data.
